// File: rtl/mult_fe_pkg.sv
// Shared definitions for the multiplier Wishbone front end: register offsets,
// CTRL/STAT bit positions and the sequencing FSM state type.
package mult_fe_pkg;

  localparam int OP_W_DEF = 16;

  localparam logic [4:0] OFF_OPA   = 5'h00;
  localparam logic [4:0] OFF_OPB   = 5'h04;
  localparam logic [4:0] OFF_CTRL  = 5'h08;
  localparam logic [4:0] OFF_PROD  = 5'h0C;
  localparam logic [4:0] OFF_COUNT = 5'h10;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_CLR_OVR  = 2;
  localparam int CTRL_IRQ_ENA  = 8;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_OVR       = 2;
  localparam int STAT_STATE_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_fe_timer.sv
// Loadable 4-bit down-counter that stops at zero; o_zero flags terminal count.
module mult_fe_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/mult_wb_frontend.sv
// Wishbone-classic register front end that launches one multiply and captures the product.
// Optional completion interrupt is built when MULT_IRQ_EN is defined.
//
// state | meaning
// IDLE  | no operation in flight
// RUN   | operands frozen on mult_a/mult_b, waiting out the multiplier latency
// DONE  | product captured, waiting for CLR_DONE or a new START
module mult_wb_frontend
  import mult_fe_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          OP_W         = OP_W_DEF,
  parameter int          MULT_LATENCY = 2,
  parameter int          CNT_W        = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [OP_W-1:0]   mult_a,
  output logic [OP_W-1:0]   mult_b,
  input  logic [2*OP_W-1:0] mult_product,
  output logic              irq_o
);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [OP_W-1:0]   r_opa, r_opb, r_mult_a, r_mult_b;
  logic [2*OP_W-1:0] r_product;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovr;
  state_t            r_state, w_state_nxt;

  logic [4:0]  w_off;
  logic        w_hit, w_wr, w_ctrl_wr;
  logic        w_start, w_clr_done, w_clr_ovr;
  logic        w_launch, w_capture, w_tmr_zero, w_irq_ena;
  logic [31:0] w_stat, w_rd_data;
  logic        w_unused;

  // An access is taken only while ack is low, so each cycle/strobe gets one ack.
  assign w_off      = wbs_adr_i[4:0];
  assign w_hit      = wbs_cyc_i & wbs_stb_i & ~r_ack &
                      (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign w_wr       = w_hit & wbs_we_i;
  assign w_ctrl_wr  = w_wr & (w_off == OFF_CTRL);
  assign w_start    = w_ctrl_wr & wbs_dat_i[CTRL_START];
  assign w_clr_done = w_ctrl_wr & wbs_dat_i[CTRL_CLR_DONE];
  assign w_clr_ovr  = w_ctrl_wr & wbs_dat_i[CTRL_CLR_OVR];
  assign w_unused   = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i};

  mult_fe_timer u_timer (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_load     (w_launch),
    .i_load_val (4'(MULT_LATENCY)),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_RUN;
          w_launch    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end
      end
      S_DONE: begin
        if (w_start) begin
          w_state_nxt = S_RUN;
          w_launch    = 1'b1;
        end else if (w_clr_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_mult_a  <= '0;
      r_mult_b  <= '0;
      r_product <= '0;
      r_count   <= '0;
      r_ovr     <= 1'b0;
    end else begin
      for (int i = 0; i < OP_W / 8; i++) begin
        if (w_wr && w_off == OFF_OPA && wbs_sel_i[i]) r_opa[8*i +: 8] <= wbs_dat_i[8*i +: 8];
        if (w_wr && w_off == OFF_OPB && wbs_sel_i[i]) r_opb[8*i +: 8] <= wbs_dat_i[8*i +: 8];
      end
      if (w_launch) begin
        r_mult_a <= r_opa;
        r_mult_b <= r_opb;
      end
      if (w_capture) begin
        r_product <= mult_product;
        r_count   <= r_count + CNT_W'(1);
      end
      // A START that collides with a run in flight is the one event that must win over a clear.
      if (w_clr_ovr) r_ovr <= 1'b0;
      if (w_start && r_state == S_RUN) r_ovr <= 1'b1;
    end
  end

`ifdef MULT_IRQ_EN
  logic r_irq_ena;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)       r_irq_ena <= 1'b0;
    else if (w_ctrl_wr) r_irq_ena <= wbs_dat_i[CTRL_IRQ_ENA];
  end

  assign w_irq_ena = r_irq_ena;
`else
  assign w_irq_ena = 1'b0;
`endif

  always_comb begin
    w_stat                             = '0;
    w_stat[STAT_BUSY]                  = (r_state == S_RUN);
    w_stat[STAT_DONE]                  = (r_state == S_DONE);
    w_stat[STAT_OVR]                   = r_ovr;
    w_stat[STAT_STATE_LSB +: 4]        = {2'b00, r_state};
    w_stat[CTRL_IRQ_ENA]               = w_irq_ena;
    case (w_off)
      OFF_OPA:   w_rd_data = 32'(r_opa);
      OFF_OPB:   w_rd_data = 32'(r_opb);
      OFF_CTRL:  w_rd_data = w_stat;
      OFF_PROD:  w_rd_data = 32'(r_product);
      OFF_COUNT: w_rd_data = 32'(r_count);
      default:   w_rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_hit;
      r_dat <= (w_hit && !wbs_we_i) ? w_rd_data : '0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign mult_a    = r_mult_a;
  assign mult_b    = r_mult_b;
  assign irq_o     = w_irq_ena & (r_state == S_DONE);

endmodule
